// File: rtl/morse_decoder_timed.sv
// morse_decoder_timed
//   Timed Morse decoder. The key level is synchronised, then mark and space
//   durations are measured with saturating counters. Completed marks are
//   classified as dot or dash by length and shifted into a code register.
//   A letter gap converts the code to ASCII. A longer word gap after a
//   character emits a single space.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   signal_in    raw key/tone level, asynchronous to clock
//   decimal_out  ASCII of the last emitted character, held until the next one
//   out_valid    one-cycle strobe, decimal_out is new this cycle
//   code_err     one-cycle strobe with out_valid when the character was undecodable
module morse_decoder_timed #(
  parameter int unsigned UNIT_CLKS  = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_ELEM   = 6,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       signal_in,
  output logic [7:0] decimal_out,
  output logic       out_valid,
  output logic       code_err
);

  localparam int unsigned ELEM_W = $clog2(MAX_ELEM + 1);

  localparam logic [CNT_W-1:0]  DASH_CLKS   = CNT_W'(2 * UNIT_CLKS);
  localparam logic [CNT_W-1:0]  LETTER_CLKS = CNT_W'(2 * UNIT_CLKS);
  localparam logic [CNT_W-1:0]  WORD_CLKS   = CNT_W'(5 * UNIT_CLKS);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [ELEM_W-1:0] ELEM_MAX    = ELEM_W'(MAX_ELEM);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_QUERY = 8'd63;

  // ITU Morse lookup. c holds the elements first-sent-in-MSB, dash = 1.
  // Returns 0 for patterns that are not a letter or digit.
  function automatic logic [7:0] morse_lookup(input int unsigned len, input logic [4:0] c);
    logic [7:0] a;
    a = 8'd0;
    case (len)
      1: a = c[0] ? 8'd84 : 8'd69;
      2: begin
        case (c[1:0])
          2'b00: a = 8'd73;  // I
          2'b01: a = 8'd65;  // A
          2'b10: a = 8'd78;  // N
          2'b11: a = 8'd77;  // M
        endcase
      end
      3: begin
        case (c[2:0])
          3'b000: a = 8'd83;  // S
          3'b001: a = 8'd85;  // U
          3'b010: a = 8'd82;  // R
          3'b011: a = 8'd87;  // W
          3'b100: a = 8'd68;  // D
          3'b101: a = 8'd75;  // K
          3'b110: a = 8'd71;  // G
          3'b111: a = 8'd79;  // O
        endcase
      end
      4: begin
        case (c[3:0])
          4'b0000: a = 8'd72;  // H
          4'b0001: a = 8'd86;  // V
          4'b0010: a = 8'd70;  // F
          4'b0100: a = 8'd76;  // L
          4'b0110: a = 8'd80;  // P
          4'b0111: a = 8'd74;  // J
          4'b1000: a = 8'd66;  // B
          4'b1001: a = 8'd88;  // X
          4'b1010: a = 8'd67;  // C
          4'b1011: a = 8'd89;  // Y
          4'b1100: a = 8'd90;  // Z
          4'b1101: a = 8'd81;  // Q
          default: a = 8'd0;
        endcase
      end
      5: begin
        case (c)
          5'b11111: a = 8'd48;
          5'b01111: a = 8'd49;
          5'b00111: a = 8'd50;
          5'b00011: a = 8'd51;
          5'b00001: a = 8'd52;
          5'b00000: a = 8'd53;
          5'b10000: a = 8'd54;
          5'b11000: a = 8'd55;
          5'b11100: a = 8'd56;
          5'b11110: a = 8'd57;
          default:  a = 8'd0;
        endcase
      end
      default: a = 8'd0;
    endcase
    return a;
  endfunction

  // Input synchroniser. Flops reset to the idle key level so that an
  // active-low key does not look like a mark when reset is released.
  logic sync1_q, sync2_q;
  logic sig_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= signal_in;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q ^ ACTIVE_LOW;

  // Duration counters
  logic             sig_prev_q;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] space_cnt_q, space_cnt_d;

  always_comb begin
    mark_cnt_d  = mark_cnt_q;
    space_cnt_d = space_cnt_q;
    if (sig_s) begin
      if (!sig_prev_q) begin
        mark_cnt_d = CNT_W'(1);
      end else if (mark_cnt_q != CNT_MAX) begin
        mark_cnt_d = mark_cnt_q + CNT_W'(1);
      end
    end else begin
      if (sig_prev_q) begin
        space_cnt_d = CNT_W'(1);
      end else if (space_cnt_q != CNT_MAX) begin
        space_cnt_d = space_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_prev_q  <= 1'b0;
      mark_cnt_q  <= '0;
      space_cnt_q <= '0;
    end else begin
      sig_prev_q  <= sig_s;
      mark_cnt_q  <= mark_cnt_d;
      space_cnt_q <= space_cnt_d;
    end
  end

  // Element accumulation FSM
  logic [1:0]          state_q, state_d;
  logic [MAX_ELEM-1:0] code_q, code_d;
  logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic                overflow_q, overflow_d;
  logic                word_pending_q, word_pending_d;
  logic                emit_char, emit_space;
  logic                is_dash;

  // Saturated marks are still >= DASH_CLKS, so they classify as dash.
  assign is_dash = (mark_cnt_q >= DASH_CLKS);

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    elem_cnt_d     = elem_cnt_q;
    overflow_d     = overflow_q;
    word_pending_d = word_pending_q;
    emit_char      = 1'b0;
    emit_space     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sig_s) state_d = ST_MARK;
      end
      ST_MARK: begin
        if (!sig_s) begin
          if (elem_cnt_q == ELEM_MAX) begin
            overflow_d = 1'b1;
          end else begin
            code_d     = {code_q[MAX_ELEM-2:0], is_dash};
            elem_cnt_d = elem_cnt_q + ELEM_W'(1);
          end
          state_d = ST_SPACE;
        end
      end
      ST_SPACE: begin
        // space_cnt only advances while low, so a mark seen here with the
        // count still below LETTER_CLKS is an intra-character gap.
        if (space_cnt_q == LETTER_CLKS) begin
          emit_char      = 1'b1;
          code_d         = '0;
          elem_cnt_d     = '0;
          overflow_d     = 1'b0;
          word_pending_d = 1'b1;
          state_d        = ST_GAP;
        end else if (sig_s) begin
          state_d = ST_MARK;
        end
      end
      ST_GAP: begin
        if (sig_s) begin
          word_pending_d = 1'b0;
          state_d        = ST_MARK;
        end else if (space_cnt_q == WORD_CLKS) begin
          emit_space     = word_pending_q;
          word_pending_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      code_q         <= '0;
      elem_cnt_q     <= '0;
      overflow_q     <= 1'b0;
      word_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      elem_cnt_q     <= elem_cnt_d;
      overflow_q     <= overflow_d;
      word_pending_q <= word_pending_d;
    end
  end

  // Character conversion and registered output
  logic [7:0] ascii;
  logic       bad_code;

  assign ascii    = morse_lookup(32'(elem_cnt_q), 5'(code_q));
  assign bad_code = overflow_q || (ascii == 8'd0);

  logic [7:0] decimal_out_q;
  logic       out_valid_q, code_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decimal_out_q <= 8'd0;
      out_valid_q   <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      out_valid_q <= emit_char | emit_space;
      code_err_q  <= emit_char & bad_code;
      if (emit_char) begin
        decimal_out_q <= bad_code ? ASCII_QUERY : ascii;
      end else if (emit_space) begin
        decimal_out_q <= ASCII_SPACE;
      end
    end
  end

  assign decimal_out = decimal_out_q;
  assign out_valid   = out_valid_q;
  assign code_err    = code_err_q;

endmodule
